// File: rtl/reset_seq_pkg.sv
// Shared types, default parameters and width helper for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT,
    SHOLD,
    RUN,
    FAULT
  } seq_state_e;

  localparam int DEF_N_STAGES       = 4;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_MAX_RETRY      = 3;

  // Never returns 0 so a degenerate parameter still yields a legal vector.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains in order, waiting on each domain's DONE
// with timeout and bounded retry; restarts on lock loss or software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int  N_STAGES       = DEF_N_STAGES,
  parameter int  HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int  MAX_RETRY      = DEF_MAX_RETRY,
  localparam int STAGE_W        = width_of(N_STAGES),
  localparam int RETRY_W        = width_of(MAX_RETRY + 1)
) (
  input  logic                clk,
  input  logic                fabric_reset_n,
  input  logic                pll_lock,
  input  logic [N_STAGES-1:0] stage_done,
  input  logic                soft_rst_req,
  output logic [N_STAGES-1:0] domain_rst_n,
  output logic                seq_done,
  output logic                seq_fault,
  output logic [STAGE_W-1:0]  fault_stage,
  output logic [RETRY_W-1:0]  retry_count
);

  localparam int HOLD_W = width_of(HOLD_CYCLES);
  localparam int TO_W   = width_of(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STAGE_W-1:0] K_LAST    = STAGE_W'(N_STAGES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic                lock_s;
  logic [N_STAGES-1:0] done_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (fabric_reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_done_sync
      sync_2ff u_done_sync (
        .clk   (clk),
        .rst_n (fabric_reset_n),
        .d     (stage_done[gi]),
        .q     (done_s[gi])
      );
    end
  endgenerate

  seq_state_e          state_reg, state_next;
  logic [STAGE_W-1:0]  k_reg, k_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [RETRY_W-1:0]  retry_reg, retry_next;
  logic [N_STAGES-1:0] dom_reg, dom_next;
  logic                done_reg, done_next;
  logic                fault_reg, fault_next;
  logic [STAGE_W-1:0]  fstage_reg, fstage_next;
  logic [N_STAGES-1:0] keep_mask;

  // Stages below the current one stay released across a retry or fault.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      keep_mask[i] = (STAGE_W'(i) < k_reg);
    end
  end

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    hold_cnt_next = hold_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    retry_next    = retry_reg;
    dom_next      = dom_reg;
    done_next     = done_reg;
    fault_next    = fault_reg;
    fstage_next   = fstage_reg;

    if (state_reg != HOLD && (!lock_s || soft_rst_req)) begin
      state_next    = HOLD;
      k_next        = '0;
      hold_cnt_next = '0;
      retry_next    = '0;
      dom_next      = '0;
      done_next     = 1'b0;
      fault_next    = 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          dom_next = '0;
          if (!lock_s || soft_rst_req) begin
            hold_cnt_next = '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            k_next        = '0;
            state_next    = RELEASE;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          dom_next[k_reg] = 1'b1;
          to_cnt_next     = '0;
          state_next      = WAIT;
        end
        WAIT: begin
          // DONE is checked first so it wins over a same-cycle timeout.
          if (done_s[k_reg]) begin
            if (k_reg == K_LAST) begin
              done_next  = 1'b1;
              state_next = RUN;
            end else begin
              k_next     = k_reg + 1'b1;
              retry_next = '0;
              state_next = RELEASE;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            dom_next = dom_reg & keep_mask;
            if (retry_reg < RETRY_MAX) begin
              retry_next    = retry_reg + 1'b1;
              hold_cnt_next = '0;
              state_next    = SHOLD;
            end else begin
              fault_next  = 1'b1;
              fstage_next = k_reg;
              state_next  = FAULT;
            end
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
        SHOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            state_next    = RELEASE;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        RUN, FAULT: begin
        end
        default: state_next = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge fabric_reset_n) begin
    if (!fabric_reset_n) begin
      state_reg    <= HOLD;
      k_reg        <= '0;
      hold_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      retry_reg    <= '0;
      dom_reg      <= '0;
      done_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      fstage_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      hold_cnt_reg <= hold_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      retry_reg    <= retry_next;
      dom_reg      <= dom_next;
      done_reg     <= done_next;
      fault_reg    <= fault_next;
      fstage_reg   <= fstage_next;
    end
  end

  assign domain_rst_n = dom_reg;
  assign seq_done     = done_reg;
  assign seq_fault    = fault_reg;
  assign fault_stage  = fstage_reg;
  assign retry_count  = retry_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer with a phase/timer reference model
// compared on every falling clock edge, plus scenario-level literal checks.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int TO   = 64;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       fabric_reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic [3:0] stage_done = 4'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] domain_rst_n;
  logic       seq_done;
  logic       seq_fault;
  logic [1:0] fault_stage;
  logic [1:0] retry_count;

  reset_sequencer #(
    .N_STAGES       (N),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk            (clk),
    .fabric_reset_n (fabric_reset_n),
    .pll_lock       (pll_lock),
    .stage_done     (stage_done),
    .soft_rst_req   (soft_rst_req),
    .domain_rst_n   (domain_rst_n),
    .seq_done       (seq_done),
    .seq_fault      (seq_fault),
    .fault_stage    (fault_stage),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_HOLD = 0, P_REL = 1, P_WAIT = 2, P_SHOLD = 3, P_RUN = 4, P_FAULT = 5;
  int         ph = P_HOLD, mk = 0, mt = 0, mretry = 0, mfs = 0;
  logic       ls1 = 1'b0, ls2 = 1'b0;
  logic [3:0] ds1 = 4'b0, ds2 = 4'b0;

  initial begin
    logic       lk;
    logic [3:0] dn;
    forever begin
      @(posedge clk or negedge fabric_reset_n);
      if (!fabric_reset_n) begin
        ph = P_HOLD; mk = 0; mt = 0; mretry = 0; mfs = 0;
        ls1 = 1'b0; ls2 = 1'b0; ds1 = 4'b0; ds2 = 4'b0;
      end else begin
        lk = ls2; dn = ds2;
        ls2 = ls1; ls1 = pll_lock;
        ds2 = ds1; ds1 = stage_done;
        if (ph != P_HOLD && (!lk || soft_rst_req)) begin
          ph = P_HOLD; mt = 0; mk = 0; mretry = 0;
        end else begin
          case (ph)
            P_HOLD: begin
              if (lk && !soft_rst_req) begin
                mt++;
                if (mt == HOLD) begin ph = P_REL; mt = 0; mk = 0; end
              end else mt = 0;
            end
            P_REL: begin ph = P_WAIT; mt = 0; end
            P_WAIT: begin
              if (dn[mk]) begin
                if (mk == N - 1) ph = P_RUN;
                else begin mk++; mretry = 0; ph = P_REL; end
              end else begin
                mt++;
                if (mt == TO) begin
                  mt = 0;
                  if (mretry < MAXR) begin mretry++; ph = P_SHOLD; end
                  else begin ph = P_FAULT; mfs = mk; end
                end
              end
            end
            P_SHOLD: begin
              mt++;
              if (mt == HOLD) begin ph = P_REL; mt = 0; end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Released domains form a contiguous low-order block whose size follows the phase.
  function automatic logic [7:0] model_vec();
    int rel;
    logic [3:0] dom;
    rel = (ph == P_WAIT) ? mk + 1 : (ph == P_RUN) ? N : (ph == P_HOLD) ? 0 : mk;
    dom = 4'((1 << rel) - 1);
    return {dom, ph == P_RUN, ph == P_FAULT, 2'(mretry)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("cycle", {24'b0, domain_rst_n, seq_done, seq_fault, retry_count}, {24'b0, model_vec()});
      if (ph == P_FAULT) check("fault_stage", {30'b0, fault_stage}, mfs);
    end
  end

  // ---------------- DONE responders ----------------
  int need[4]     = '{1, 1, 1, 1};
  int delay[4]    = '{5, 5, 5, 5};
  int attempts[4] = '{0, 0, 0, 0};
  int rcnt[4]     = '{0, 0, 0, 0};

  initial begin
    logic [3:0] dom_prev = 4'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (domain_rst_n[i] === 1'b1) begin
          if (!dom_prev[i]) begin attempts[i]++; rcnt[i] = 0; end
          rcnt[i]++;
          stage_done[i] = (attempts[i] >= need[i]) && (rcnt[i] > delay[i]);
        end else stage_done[i] = 1'b0;
      end
      dom_prev = domain_rst_n;
    end
  end

  logic [3:0] changes[$];
  initial begin
    logic [3:0] last = 4'b0;
    forever begin
      @(negedge clk);
      if (domain_rst_n !== last) begin changes.push_back(domain_rst_n); last = domain_rst_n; end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_until(input int what, input logic [3:0] val, input int max_cyc, input string tag);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      case (what)
        0: hit = seq_done;
        1: hit = seq_fault;
        2: hit = (retry_count == val[1:0]);
        3: hit = (domain_rst_n == val);
        default: hit = seq_done | seq_fault;
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: condition not reached after %0d cycles", tag, n);
    end
  endtask

  task automatic soft_pulse();
    @(negedge clk);
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    for (int i = 0; i < 4; i++) attempts[i] = 0;
  endtask

  task automatic count_to_release(output int n);
    n = 0;
    while (domain_rst_n[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [15:0] packed_steps();
    logic [15:0] s = 16'h0;
    for (int i = 0; i < changes.size() && i < 4; i++) s[i*4 +: 4] = changes[i];
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 500000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int n;
    logic exp_fault;
    int   exp_stage;

    repeat (3) @(negedge clk);
    check("reset_dom", {28'b0, domain_rst_n}, 0);
    check("reset_done", {31'b0, seq_done}, 0);
    check("reset_fault", {31'b0, seq_fault}, 0);
    check("reset_retry", {30'b0, retry_count}, 0);
    check("reset_fstage", {30'b0, fault_stage}, 0);
    #2 fabric_reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal: every DONE 5 cycles after its release.
    changes.delete();
    pll_lock = 1'b1;
    count_to_release(n);
    check("first_release_latency", n, 19);
    wait_until(0, 4'h0, 1000, "nominal_done");
    check("nominal_steps_count", changes.size(), 4);
    check("nominal_steps", packed_steps(), 16'hF731);
    $display("scenario nominal: domains=%b seq_done=%b", domain_rst_n, seq_done);

    // Timeout/retry on stage 2.
    need[2] = 2;
    soft_pulse();
    wait_until(3, 4'b0111, 1000, "retry_reach_stage2");
    n = 0;
    while (domain_rst_n[2] === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("retry_stage2_high_cycles", n, 64);
    check("retry_dom_after_timeout", {28'b0, domain_rst_n}, 4'b0011);
    check("retry_count_after_timeout", {30'b0, retry_count}, 1);
    wait_until(0, 4'h0, 1000, "retry_done");
    check("retry_final_dom", {28'b0, domain_rst_n}, 4'b1111);
    $display("scenario retry: domains=%b seq_done=%b", domain_rst_n, seq_done);

    // Fault on stage 1, then software restart.
    need[1] = 99; need[2] = 1;
    soft_pulse();
    wait_until(1, 4'h0, 2000, "fault_reached");
    check("fault_stage_lit", {30'b0, fault_stage}, 1);
    check("fault_dom", {28'b0, domain_rst_n}, 4'b0001);
    check("fault_retry", {30'b0, retry_count}, 2);
    check("fault_done_low", {31'b0, seq_done}, 0);
    soft_pulse();
    check("fault_restart_dom", {28'b0, domain_rst_n}, 0);
    check("fault_restart_flag", {31'b0, seq_fault}, 0);
    need[1] = 1;
    wait_until(0, 4'h0, 1000, "fault_recover_done");
    $display("scenario fault: stage=%0d recovered seq_done=%b", fault_stage, seq_done);

    // Lock loss while running.
    for (int i = 0; i < 4; i++) delay[i] = $urandom_range(1, 40);
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("lockloss_dom", {28'b0, domain_rst_n}, 0);
    check("lockloss_done", {31'b0, seq_done}, 0);
    repeat (7) @(negedge clk);
    pll_lock = 1'b1;
    wait_until(0, 4'h0, 1000, "lockloss_recover_done");
    $display("scenario lock loss: domains=%b seq_done=%b", domain_rst_n, seq_done);

    // Two-cycle lock glitch at hold count 10.
    soft_pulse();
    repeat (10) @(negedge clk);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    pll_lock = 1'b1;
    count_to_release(n);
    check("glitch_release_latency", n, 19);
    wait_until(0, 4'h0, 1000, "glitch_done");
    $display("scenario lock glitch: release after %0d cycles", n);

    // Asynchronous reset while waiting on stage 2.
    need[2] = 99;
    soft_pulse();
    wait_until(3, 4'b0111, 1000, "areset_reach_stage2");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 fabric_reset_n = 1'b0;
    #1 check("areset_immediate_dom", {28'b0, domain_rst_n}, 0);
    @(negedge clk);
    #2 fabric_reset_n = 1'b1;
    need[2] = 1;
    for (int i = 0; i < 4; i++) attempts[i] = 0;
    repeat (2) @(negedge clk);
    changes.delete();
    wait_until(0, 4'h0, 1000, "areset_restart_done");
    check("areset_steps", packed_steps(), 16'hF731);
    $display("scenario async reset: domains=%b seq_done=%b", domain_rst_n, seq_done);

    // Random sequences: need in 1..4 attempts, random DONE delays.
    for (int it = 0; it < 5; it++) begin
      exp_fault = 1'b0;
      exp_stage = 0;
      for (int i = 0; i < 4; i++) begin
        need[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : 1;
        delay[i] = $urandom_range(1, 50);
      end
      for (int i = 3; i >= 0; i--) if (need[i] > MAXR + 1) begin exp_fault = 1'b1; exp_stage = i; end
      soft_pulse();
      wait_until(4, 4'h0, 3000, "random_settle");
      check("random_fault_flag", {31'b0, seq_fault}, {31'b0, exp_fault});
      if (exp_fault) check("random_fault_stage", {30'b0, fault_stage}, exp_stage);
      $display("random %0d: need=%0d%0d%0d%0d domains=%b done=%b fault=%b",
               it, need[3], need[2], need[1], need[0], domain_rst_n, seq_done, seq_fault);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
